// File: rtl/pipe_msgbus_endpoint.sv
// MAC-side PIPE message-bus endpoint: serialises commands onto M2P, parses P2M,
// and shadows the DP link-training status registers written by the PHY.
module pipe_msgbus_endpoint (
  input  logic        pclk,
  input  logic        reset_n,
  input  logic [3:0]  cmd_in,
  input  logic [11:0] addr_in,
  input  logic [7:0]  data_in,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic        wait_ack_en,
  input  logic        write_ack_en,
  output logic [7:0]  m2p_message_bus,
  input  logic [7:0]  p2m_message_bus,
  output logic [3:0]  cmd_out,
  output logic [11:0] addr_out,
  output logic [7:0]  data_out,
  output logic        rx_valid,
  output logic [1:0]  tx_state,
  output logic [1:0]  rx_state,
  output logic        link_trg_en,
  output logic [2:0]  link_trg_stage,
  output logic [2:0]  link_trg_tps,
  output logic [3:0]  data_rate
);

  localparam logic [3:0] CMD_WR_U   = 4'd1;
  localparam logic [3:0] CMD_WR_C   = 4'd2;
  localparam logic [3:0] CMD_RD     = 4'd3;
  localparam logic [3:0] CMD_RD_CPL = 4'd4;
  localparam logic [3:0] CMD_WR_ACK = 4'd5;
  localparam logic [7:0] ACK_BEAT   = {CMD_WR_ACK, 4'h0};

  typedef enum logic [1:0] {TX_IDLE = 2'd0, TX_ADDR_LO = 2'd1, TX_DATA = 2'd2, TX_WAIT_ACK = 2'd3} txState_t;
  typedef enum logic [1:0] {RX_IDLE = 2'd0, RX_ADDR_LO = 2'd1, RX_DATA = 2'd2} rxState_t;

  txState_t    r_txState, w_txNext;
  rxState_t    r_rxState, w_rxNext;
  logic [7:0]  r_m2p, w_busNext;
  logic [3:0]  r_txCmd;
  logic [7:0]  r_txAddrLo, r_txData;
  logic        r_txWait, r_ackPending;
  logic        w_accept, w_ackSend, w_ackSet, w_ackDone;
  logic [3:0]  r_rxCmd, r_rxAddrHi;
  logic [7:0]  r_rxAddrLo;
  logic [3:0]  r_cmdOut;
  logic [11:0] r_addrOut;
  logic [7:0]  r_dataOut;
  logic        r_rxValid;
  logic        r_linkEn;
  logic [2:0]  r_linkStage, r_linkTps;
  logic [3:0]  r_dataRate;
  logic [3:0]  w_beatCmd, w_doneCmd;
  logic [11:0] w_doneAddr;
  logic        w_beatValid, w_rxDone, w_isWrite, w_carriesAddr, w_carriesData;

  assign tx_ready        = (r_txState == TX_IDLE) && !r_ackPending;
  assign tx_state        = r_txState;
  assign rx_state        = r_rxState;
  assign m2p_message_bus = r_m2p;
  assign cmd_out         = r_cmdOut;
  assign addr_out        = r_addrOut;
  assign data_out        = r_dataOut;
  assign rx_valid        = r_rxValid;
  assign link_trg_en     = r_linkEn;
  assign link_trg_stage  = r_linkStage;
  assign link_trg_tps    = r_linkTps;
  assign data_rate       = r_dataRate;

  // The wait is released by the registered completion, so tx_ready follows rx_valid by one cycle
  assign w_ackDone = r_rxValid &&
                     (((r_txCmd == CMD_WR_C) && (r_cmdOut == CMD_WR_ACK)) ||
                      ((r_txCmd == CMD_RD) && (r_cmdOut == CMD_RD_CPL)));
  assign w_ackSet  = w_rxDone && (w_doneCmd == CMD_WR_C) && write_ack_en;

  always_comb begin
    w_txNext  = r_txState;
    w_busNext = 8'h00;
    w_accept  = 1'b0;
    w_ackSend = 1'b0;
    case (r_txState)
      TX_IDLE: begin
        if (r_ackPending) begin
          w_busNext = ACK_BEAT;
          w_ackSend = 1'b1;
        end else if (tx_valid) begin
          w_accept = 1'b1;
          case (cmd_in)
            CMD_WR_U, CMD_WR_C, CMD_RD: begin
              w_busNext = {cmd_in, addr_in[11:8]};
              w_txNext  = TX_ADDR_LO;
            end
            CMD_RD_CPL: begin
              w_busNext = {CMD_RD_CPL, 4'h0};
              w_txNext  = TX_DATA;
            end
            CMD_WR_ACK: w_busNext = ACK_BEAT;
            default:    w_busNext = 8'h00;
          endcase
        end
      end
      TX_ADDR_LO: begin
        w_busNext = r_txAddrLo;
        if (r_txCmd == CMD_RD) w_txNext = r_txWait ? TX_WAIT_ACK : TX_IDLE;
        else                   w_txNext = TX_DATA;
      end
      TX_DATA: begin
        w_busNext = r_txData;
        w_txNext  = r_txWait ? TX_WAIT_ACK : TX_IDLE;
      end
      TX_WAIT_ACK: begin
        if (r_ackPending) begin
          w_busNext = ACK_BEAT;
          w_ackSend = 1'b1;
        end
        if (w_ackDone) w_txNext = TX_IDLE;
      end
      default: w_txNext = TX_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      r_txState    <= TX_IDLE;
      r_m2p        <= 8'h00;
      r_txCmd      <= 4'h0;
      r_txAddrLo   <= 8'h00;
      r_txData     <= 8'h00;
      r_txWait     <= 1'b0;
      r_ackPending <= 1'b0;
    end else begin
      r_txState <= w_txNext;
      r_m2p     <= w_busNext;
      if (w_accept) begin
        r_txCmd    <= cmd_in;
        r_txAddrLo <= addr_in[7:0];
        r_txData   <= data_in;
        r_txWait   <= wait_ack_en && ((cmd_in == CMD_WR_C) || (cmd_in == CMD_RD));
      end
      if (w_ackSet)       r_ackPending <= 1'b1;
      else if (w_ackSend) r_ackPending <= 1'b0;
    end
  end

  assign w_beatCmd     = p2m_message_bus[7:4];
  assign w_beatValid   = (w_beatCmd >= CMD_WR_U) && (w_beatCmd <= CMD_WR_ACK);
  assign w_doneCmd     = (r_rxState == RX_IDLE) ? w_beatCmd : r_rxCmd;
  assign w_doneAddr    = (r_rxState == RX_ADDR_LO) ? {r_rxAddrHi, p2m_message_bus}
                                                   : {r_rxAddrHi, r_rxAddrLo};
  assign w_isWrite     = (w_doneCmd == CMD_WR_U) || (w_doneCmd == CMD_WR_C);
  assign w_carriesAddr = w_isWrite || (w_doneCmd == CMD_RD);
  assign w_carriesData = w_isWrite || (w_doneCmd == CMD_RD_CPL);

  always_comb begin
    w_rxNext = r_rxState;
    w_rxDone = 1'b0;
    case (r_rxState)
      RX_IDLE: begin
        if (w_beatValid) begin
          if (w_beatCmd == CMD_WR_ACK)      w_rxDone = 1'b1;
          else if (w_beatCmd == CMD_RD_CPL) w_rxNext = RX_DATA;
          else                              w_rxNext = RX_ADDR_LO;
        end
      end
      RX_ADDR_LO: begin
        if (r_rxCmd == CMD_RD) begin
          w_rxDone = 1'b1;
          w_rxNext = RX_IDLE;
        end else begin
          w_rxNext = RX_DATA;
        end
      end
      RX_DATA: begin
        w_rxDone = 1'b1;
        w_rxNext = RX_IDLE;
      end
      default: w_rxNext = RX_IDLE;
    endcase
  end

  // Completion publishes only the fields the command carries; status shadow rides the same edge
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      r_rxState   <= RX_IDLE;
      r_rxCmd     <= 4'h0;
      r_rxAddrHi  <= 4'h0;
      r_rxAddrLo  <= 8'h00;
      r_rxValid   <= 1'b0;
      r_cmdOut    <= 4'h0;
      r_addrOut   <= 12'h000;
      r_dataOut   <= 8'h00;
      r_linkEn    <= 1'b0;
      r_linkStage <= 3'd0;
      r_linkTps   <= 3'd0;
      r_dataRate  <= 4'h0;
    end else begin
      r_rxState <= w_rxNext;
      r_rxValid <= w_rxDone;
      if ((r_rxState == RX_IDLE) && w_beatValid) begin
        r_rxCmd    <= w_beatCmd;
        r_rxAddrHi <= p2m_message_bus[3:0];
      end
      if (r_rxState == RX_ADDR_LO) r_rxAddrLo <= p2m_message_bus;
      if (w_rxDone) begin
        r_cmdOut <= w_doneCmd;
        if (w_carriesAddr) r_addrOut <= w_doneAddr;
        if (w_carriesData) r_dataOut <= p2m_message_bus;
        if (w_isWrite) begin
          case (w_doneAddr)
            12'hF00: r_linkEn    <= p2m_message_bus[0];
            12'hF01: r_linkStage <= p2m_message_bus[2:0];
            12'hF02: r_linkTps   <= p2m_message_bus[2:0];
            12'hF03: r_dataRate  <= p2m_message_bus[3:0];
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_msgbus_endpoint.sv
// Scoreboard bench for pipe_msgbus_endpoint: queued expected M2P beats and RX completions.
module tb_pipe_msgbus_endpoint;

  logic        pclk = 1'b0;
  logic        reset_n;
  logic [3:0]  cmd_in;
  logic [11:0] addr_in;
  logic [7:0]  data_in;
  logic        tx_valid, tx_ready, wait_ack_en, write_ack_en;
  logic [7:0]  m2p_message_bus, p2m_message_bus;
  logic [3:0]  cmd_out;
  logic [11:0] addr_out;
  logic [7:0]  data_out;
  logic        rx_valid;
  logic [1:0]  tx_state, rx_state;
  logic        link_trg_en;
  logic [2:0]  link_trg_stage, link_trg_tps;
  logic [3:0]  data_rate;

  int checks = 0;
  int passes = 0;

  logic [7:0]  txExp[$];
  logic [23:0] rxExp[$];

  logic [3:0]  mCmd;
  logic [11:0] mAddr;
  logic [7:0]  mData;
  logic        mEn;
  logic [2:0]  mStage, mTps;
  logic [3:0]  mRate;

  pipe_msgbus_endpoint dut (
    .pclk(pclk), .reset_n(reset_n),
    .cmd_in(cmd_in), .addr_in(addr_in), .data_in(data_in),
    .tx_valid(tx_valid), .tx_ready(tx_ready),
    .wait_ack_en(wait_ack_en), .write_ack_en(write_ack_en),
    .m2p_message_bus(m2p_message_bus), .p2m_message_bus(p2m_message_bus),
    .cmd_out(cmd_out), .addr_out(addr_out), .data_out(data_out),
    .rx_valid(rx_valid), .tx_state(tx_state), .rx_state(rx_state),
    .link_trg_en(link_trg_en), .link_trg_stage(link_trg_stage),
    .link_trg_tps(link_trg_tps), .data_rate(data_rate)
  );

  always #5 pclk = ~pclk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model of the RX outputs and status shadow; pushes the expected completion.
  function automatic void expectRx(input logic [3:0] c, input logic [11:0] a, input logic [7:0] d);
    mCmd = c;
    if (c == 4'd1 || c == 4'd2 || c == 4'd3) mAddr = a;
    if (c == 4'd1 || c == 4'd2 || c == 4'd4) mData = d;
    if (c == 4'd1 || c == 4'd2) begin
      case (a)
        12'hF00: mEn    = d[0];
        12'hF01: mStage = d[2:0];
        12'hF02: mTps   = d[2:0];
        12'hF03: mRate  = d[3:0];
        default: ;
      endcase
    end
    rxExp.push_back({mCmd, mAddr, mData});
  endfunction

  function automatic void modelReset();
    mCmd = 4'h0; mAddr = 12'h000; mData = 8'h00;
    mEn = 1'b0; mStage = 3'd0; mTps = 3'd0; mRate = 4'h0;
  endfunction

  task automatic driveBeat(input logic [7:0] b);
    p2m_message_bus = b;
    @(negedge pclk);
  endtask

  task automatic waitRxValid(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (rx_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge pclk);
    end
  endtask

  task automatic test_reset;
    checks++;
    if (m2p_message_bus !== 8'h00 || rx_valid !== 1'b0) $display("[TB] FAIL reset_bus: m2p=%h rx_valid=%b, required 00/0", m2p_message_bus, rx_valid);
    else passes++;
    checks++;
    if (tx_state !== 2'd0 || rx_state !== 2'd0) $display("[TB] FAIL reset_states: tx=%0d rx=%0d, required 0/0", tx_state, rx_state);
    else passes++;
    checks++;
    if (tx_ready !== 1'b1) $display("[TB] FAIL reset_ready: tx_ready=%b, required 1", tx_ready);
    else passes++;
    checks++;
    if ({cmd_out, addr_out, data_out} !== 24'h0) $display("[TB] FAIL reset_fields: %h, required 000000", {cmd_out, addr_out, data_out});
    else passes++;
    checks++;
    if ({link_trg_en, link_trg_stage, link_trg_tps, data_rate} !== 11'h0) $display("[TB] FAIL reset_status: %h, required 000", {link_trg_en, link_trg_stage, link_trg_tps, data_rate});
    else passes++;
  endtask

  task automatic test_tx_write;
    logic [7:0] exp;
    cmd_in = 4'd2; addr_in = 12'h123; data_in = 8'hA5; wait_ack_en = 1'b0; tx_valid = 1'b1;
    txExp.push_back(8'h21); txExp.push_back(8'h23); txExp.push_back(8'hA5); txExp.push_back(8'h00);
    @(negedge pclk);
    tx_valid = 1'b0;
    while (txExp.size() > 0) begin
      exp = txExp.pop_front();
      checks++;
      if (m2p_message_bus !== exp) $display("[TB] FAIL tx_write_beat: m2p=%h, required %h", m2p_message_bus, exp);
      else passes++;
      @(negedge pclk);
    end
    checks++;
    if (tx_ready !== 1'b1 || tx_state !== 2'd0) $display("[TB] FAIL tx_write_ready: tx_ready=%b tx_state=%0d, required 1/0", tx_ready, tx_state);
    else passes++;
  endtask

  task automatic test_rx_read;
    bit seen;
    logic [23:0] exp;
    expectRx(4'd3, 12'h145, 8'h00);
    driveBeat(8'h31);
    driveBeat(8'h45);
    p2m_message_bus = 8'h00;
    waitRxValid(seen);
    checks++;
    if (!seen) $display("[TB] FAIL rx_read_valid: rx_valid=0, required a pulse");
    else begin
      passes++;
      exp = rxExp.pop_front();
      checks++;
      if ({cmd_out, addr_out, data_out} !== exp) $display("[TB] FAIL rx_read_fields: %h, required %h", {cmd_out, addr_out, data_out}, exp);
      else passes++;
    end
    @(negedge pclk);
    checks++;
    if (rx_valid !== 1'b0) $display("[TB] FAIL rx_read_pulse: rx_valid=%b, required 0", rx_valid);
    else passes++;
  endtask

  task automatic test_wait_ack;
    bit seen;
    logic [7:0] exp;
    logic [23:0] expRx;
    cmd_in = 4'd3; addr_in = 12'h010; data_in = 8'h00; wait_ack_en = 1'b1; tx_valid = 1'b1;
    txExp.push_back(8'h30); txExp.push_back(8'h10); txExp.push_back(8'h00);
    @(negedge pclk);
    tx_valid = 1'b0;
    wait_ack_en = 1'b0;
    while (txExp.size() > 0) begin
      exp = txExp.pop_front();
      checks++;
      if (m2p_message_bus !== exp) $display("[TB] FAIL wait_ack_beat: m2p=%h, required %h", m2p_message_bus, exp);
      else passes++;
      @(negedge pclk);
    end
    checks++;
    if (tx_state !== 2'd3 || tx_ready !== 1'b0) $display("[TB] FAIL wait_ack_hold: tx_state=%0d tx_ready=%b, required 3/0", tx_state, tx_ready);
    else passes++;
    expectRx(4'd4, 12'h000, 8'h7E);
    driveBeat(8'h40);
    driveBeat(8'h7E);
    p2m_message_bus = 8'h00;
    waitRxValid(seen);
    checks++;
    if (!seen) $display("[TB] FAIL wait_ack_cpl: rx_valid=0, required a pulse");
    else begin
      passes++;
      expRx = rxExp.pop_front();
      checks++;
      if ({cmd_out, addr_out, data_out} !== expRx) $display("[TB] FAIL wait_ack_fields: %h, required %h", {cmd_out, addr_out, data_out}, expRx);
      else passes++;
    end
    @(negedge pclk);
    checks++;
    if (tx_state !== 2'd0 || tx_ready !== 1'b1) $display("[TB] FAIL wait_ack_release: tx_state=%0d tx_ready=%b, required 0/1", tx_state, tx_ready);
    else passes++;
  endtask

  task automatic test_auto_ack;
    bit seen;
    logic [7:0] exp;
    logic [23:0] expRx;
    write_ack_en = 1'b1;
    expectRx(4'd2, 12'hF01, 8'h05);
    driveBeat(8'h2F);
    driveBeat(8'h01);
    driveBeat(8'h05);
    p2m_message_bus = 8'h00;
    waitRxValid(seen);
    checks++;
    if (!seen) $display("[TB] FAIL auto_ack_rx: rx_valid=0, required a pulse");
    else begin
      passes++;
      expRx = rxExp.pop_front();
      checks++;
      if ({cmd_out, addr_out, data_out} !== expRx) $display("[TB] FAIL auto_ack_fields: %h, required %h", {cmd_out, addr_out, data_out}, expRx);
      else passes++;
    end
    checks++;
    if (link_trg_stage !== mStage) $display("[TB] FAIL auto_ack_stage: link_trg_stage=%0d, required %0d", link_trg_stage, mStage);
    else passes++;
    write_ack_en = 1'b0;
    cmd_in = 4'd1; addr_in = 12'h0AB; data_in = 8'h3C; tx_valid = 1'b1;
    txExp.push_back(8'h50); txExp.push_back(8'h10); txExp.push_back(8'hAB); txExp.push_back(8'h3C); txExp.push_back(8'h00);
    checks++;
    if (tx_ready !== 1'b0) $display("[TB] FAIL auto_ack_stall: tx_ready=%b, required 0", tx_ready);
    else passes++;
    @(negedge pclk);
    exp = txExp.pop_front();
    checks++;
    if (m2p_message_bus !== exp) $display("[TB] FAIL auto_ack_beat: m2p=%h, required %h", m2p_message_bus, exp);
    else passes++;
    @(negedge pclk);
    tx_valid = 1'b0;
    while (txExp.size() > 0) begin
      exp = txExp.pop_front();
      checks++;
      if (m2p_message_bus !== exp) $display("[TB] FAIL auto_ack_req_beat: m2p=%h, required %h", m2p_message_bus, exp);
      else passes++;
      @(negedge pclk);
    end
  endtask

  task automatic test_status_reserved;
    bit seen;
    bit sawBad;
    logic [23:0] expRx;
    expectRx(4'd1, 12'hF03, 8'h0A);
    driveBeat(8'h1F);
    driveBeat(8'h03);
    driveBeat(8'h0A);
    waitRxValid(seen);
    checks++;
    if (!seen) $display("[TB] FAIL status_rx: rx_valid=0, required a pulse");
    else begin
      passes++;
      expRx = rxExp.pop_front();
      checks++;
      if ({cmd_out, addr_out, data_out} !== expRx) $display("[TB] FAIL status_fields: %h, required %h", {cmd_out, addr_out, data_out}, expRx);
      else passes++;
    end
    checks++;
    if (data_rate !== mRate) $display("[TB] FAIL status_rate: data_rate=%h, required %h", data_rate, mRate);
    else passes++;
    driveBeat(8'h9F);
    p2m_message_bus = 8'h00;
    sawBad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (rx_valid !== 1'b0 || rx_state !== 2'd0) sawBad = 1'b1;
      @(negedge pclk);
    end
    checks++;
    if (sawBad) $display("[TB] FAIL reserved_ignored: rx_valid/rx_state changed, required 0/0");
    else passes++;
  endtask

  task automatic test_back_to_back;
    bit seen;
    logic [23:0] expRx;
    logic [7:0] beats[12];
    beats = '{8'h2F, 8'h00, 8'h01, 8'h50, 8'h1F, 8'h02, 8'h0E, 8'h1F, 8'h04, 8'hFF, 8'h00, 8'h00};
    expectRx(4'd2, 12'hF00, 8'h01);
    expectRx(4'd5, 12'h000, 8'h00);
    expectRx(4'd1, 12'hF02, 8'h0E);
    expectRx(4'd1, 12'hF04, 8'hFF);
    for (int i = 0; i < 10; i++) begin
      driveBeat(beats[i]);
      if (rx_valid === 1'b1) begin
        expRx = rxExp.pop_front();
        checks++;
        if ({cmd_out, addr_out, data_out} !== expRx) $display("[TB] FAIL b2b_fields: %h, required %h", {cmd_out, addr_out, data_out}, expRx);
        else passes++;
      end
    end
    p2m_message_bus = 8'h00;
    checks++;
    if (rxExp.size() != 0) $display("[TB] FAIL b2b_count: %0d completions missing, required 0", rxExp.size());
    else passes++;
    rxExp.delete();
    waitRxValid(seen);
    checks++;
    if ({link_trg_en, link_trg_stage, link_trg_tps, data_rate} !== {mEn, mStage, mTps, mRate})
      $display("[TB] FAIL b2b_status: %h, required %h", {link_trg_en, link_trg_stage, link_trg_tps, data_rate}, {mEn, mStage, mTps, mRate});
    else passes++;
    @(negedge pclk);
  endtask

  task automatic test_reset_mid;
    cmd_in = 4'd1; addr_in = 12'h234; data_in = 8'h77; tx_valid = 1'b1;
    @(negedge pclk);
    tx_valid = 1'b0;
    p2m_message_bus = 8'h1F;
    @(negedge pclk);
    checks++;
    if (tx_state !== 2'd2 || m2p_message_bus !== 8'h34) $display("[TB] FAIL mid_pre: tx_state=%0d m2p=%h, required 2/34", tx_state, m2p_message_bus);
    else passes++;
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (m2p_message_bus !== 8'h00 || tx_state !== 2'd0 || rx_state !== 2'd0)
      $display("[TB] FAIL mid_async: m2p=%h tx=%0d rx=%0d, required 00/0/0", m2p_message_bus, tx_state, rx_state);
    else passes++;
    modelReset();
    p2m_message_bus = 8'h00;
    @(negedge pclk);
    reset_n = 1'b1;
    checks++;
    if (tx_ready !== 1'b1 || {link_trg_en, link_trg_stage, link_trg_tps, data_rate} !== {mEn, mStage, mTps, mRate})
      $display("[TB] FAIL mid_release: tx_ready=%b status=%h, required 1/%h", tx_ready, {link_trg_en, link_trg_stage, link_trg_tps, data_rate}, {mEn, mStage, mTps, mRate});
    else passes++;
    @(negedge pclk);
  endtask

  initial begin
    reset_n = 1'b0;
    cmd_in = 4'h0; addr_in = 12'h000; data_in = 8'h00;
    tx_valid = 1'b0; wait_ack_en = 1'b0; write_ack_en = 1'b0;
    p2m_message_bus = 8'h00;
    modelReset();
    repeat (3) @(negedge pclk);
    reset_n = 1'b1;
    test_reset();
    test_tx_write();
    test_rx_read();
    test_wait_ack();
    test_auto_ack();
    test_status_reserved();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pipe_msgbus_endpoint.md
# pipe_msgbus_endpoint

MAC-side PIPE message-bus endpoint with a link-training status shadow.
- The transmit side serialises commands onto the 8-bit M2P message bus.
- The receive side parses the 8-bit P2M message bus into command, address and data fields.
- PHY writes to a small address window update a DP link-training status register set.
- The block sits between the PHY pipe interface and the bench/controller logic, and exposes its tx/rx state machines for debug.

## Interface
- No parameters; bus width fixed at 8, address 12, data 8.
- `pclk` in 1: sole clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `cmd_in` in 4: command to transmit.
- `addr_in` in 12: address to transmit.
- `data_in` in 8: data to transmit.
- `tx_valid` in 1: request; transfer occurs when `tx_valid & tx_ready`.
- `tx_ready` out 1: endpoint can accept a request.
- `wait_ack_en` in 1: block after write_committed/read until write_ack/read_completion arrives.
- `write_ack_en` in 1: auto-send write_ack for every received write_committed.
- `m2p_message_bus` out 8: registered M2P bus.
- `p2m_message_bus` in 8: P2M bus, sampled each `pclk`.
- `cmd_out` out 4: last received command, registered.
- `addr_out` out 12: last received address, registered.
- `data_out` out 8: last received data, registered.
- `rx_valid` out 1: one-cycle pulse when a received command is complete.
- `tx_state` out 2: TX_IDLE=0, TX_ADDR_LO=1, TX_DATA=2, TX_WAIT_ACK=3.
- `rx_state` out 2: RX_IDLE=0, RX_ADDR_LO=1, RX_DATA=2.
- `link_trg_en` out 1, `link_trg_stage` out 3, `link_trg_tps` out 3, `data_rate` out 4: status shadow registers.

## Operation
- **Command encodings [7:4]:**
  - NOP=0, write_uncommitted=1, write_committed=2, read=3, read_completion=4, write_ack=5.
  - Codes 6–15 are reserved: treated as NOP (ignored, state stays idle).
- **Beat formats:**
  - Writes: {cmd, addr[11:8]}, addr[7:0], data.
  - Read: {cmd, addr[11:8]}, addr[7:0].
  - read_completion: {4, 0}, data.
  - write_ack: {5, 0}.
- **TX FSM:**
  - From TX_IDLE, an accepted request drives its first beat and moves to TX_ADDR_LO.
  - Read: TX_ADDR_LO → TX_IDLE.
  - Writes: TX_ADDR_LO → TX_DATA → TX_IDLE.
  - read_completion: first beat → TX_DATA → TX_IDLE.
  - write_ack: single beat, stays in TX_IDLE.
  - If `wait_ack_en` is set and the command was write_committed or read, the last beat goes to TX_WAIT_ACK instead of TX_IDLE.
  - TX_WAIT_ACK exits to TX_IDLE when RX completes write_ack (for a write) or read_completion (for a read). There is no timeout.
  - `wait_ack_en` is sampled at the request's acceptance.
- **tx_ready:** high only in TX_IDLE with no pending auto-ack.
- **RX FSM:**
  - RX_IDLE, on a valid non-NOP command beat: latch cmd and addr[11:8].
  - write_ack: completes immediately.
  - read_completion: go to RX_DATA.
  - Otherwise: go to RX_ADDR_LO.
  - RX_ADDR_LO: latch addr[7:0]; read completes, writes go to RX_DATA.
  - RX_DATA: latch data, complete.
  - Completion updates `cmd_out`/`addr_out`/`data_out` and pulses `rx_valid`. Fields not carried by the command keep their previous values.
- **Auto-ack:**
  - A received write_committed with `write_ack_en`=1 sets a 1-deep pending flag.
  - The write_ack beat is sent in the first cycle TX is in TX_IDLE or TX_WAIT_ACK and not driving another beat.
  - The auto-ack has priority over a new request.
  - A second ack arriving while one is pending is dropped.
- **Status window:** a completed write (either type) to one of these addresses updates the shadow register; other addresses leave status unchanged.
  - 0xF00: `link_trg_en` = data[0].
  - 0xF01: `link_trg_stage` = data[2:0].
  - 0xF02: `link_trg_tps` = data[2:0].
  - 0xF03: `data_rate` = data[3:0].

## Timing
- **Reset values:** all outputs 0; states IDLE; pending flag cleared; `tx_ready` 1 after reset release.
- **Reset mid-transfer:** `m2p_message_bus` returns to 0 immediately (asynchronously) and the transfer is abandoned.
- **TX latency:** request accepted at edge N; beats appear in cycles N+1, N+2, N+3; bus is 0 whenever no beat is driven.
- **TX throughput:** next request accepted no earlier than the edge of the last beat, giving back-to-back beats with no gap.
- **RX latency:** `rx_valid` and fields update one cycle after the final beat is sampled.
- **RX back-to-back:** a new command beat immediately after the final beat is accepted.
- **Status registers:** update in the same cycle as `rx_valid`.
- **Ack release:** a matching write_ack/read_completion clears TX_WAIT_ACK on the cycle `rx_valid` pulses; `tx_ready` rises the next cycle.

## Test plan
- After reset, TX request write_committed addr 0x123 data 0xA5 with `wait_ack_en`=0 → `m2p_message_bus` shows 0x21, 0x23, 0xA5, then 0x00; `tx_ready` returns to 1.
- P2M drives 0x31, 0x45 (read addr 0x145) → `rx_valid` pulse; `cmd_out`=3, `addr_out`=0x145; `data_out` unchanged.
- `wait_ack_en`=1, send read 0x010 → `tx_state`=3 and `tx_ready`=0; P2M drives 0x40, 0x7E → `data_out`=0x7E, `tx_state` back to 0.
- `write_ack_en`=1, P2M drives write_committed 0xF01 data 0x05 → `link_trg_stage`=5 and one M2P beat 0x50; a concurrent `tx_valid` is stalled until the ack beat is sent.
- P2M write_uncommitted 0xF03 data 0x0A, then reserved beat 0x9F → `data_rate`=0xA; reserved beat produces no `rx_valid`.
- Assert `reset_n` low during TX_DATA → `m2p_message_bus`=0 and both states 0 without waiting for `pclk`.
